// File: rtl/key_led_ctrl_multi.sv
// key_led_ctrl_multi: N-channel push-button front end. Each channel has a 2-flop
// synchroniser, a debounce FSM producing press/release/long-press pulses, and an
// LED register driven by a mode shared by all channels.
// Optional build macro KEY_REPEAT_EN: key_long_flag re-pulses every REPEAT_CNT
// cycles while the key stays held after the first long-press pulse.
module key_led_ctrl_multi #(
    parameter int KEY_NUM      = 4,
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int LONG_CNT     = 50000000,
    parameter bit KEY_ACTIVE   = 1'b0,
    parameter int REPEAT_CNT   = 10000000
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key,
    input  logic [1:0]         mode,
    output logic [KEY_NUM-1:0] key_out,
    output logic [KEY_NUM-1:0] key_p_flag,
    output logic [KEY_NUM-1:0] key_r_flag,
    output logic [KEY_NUM-1:0] key_long_flag,
    output logic [KEY_NUM-1:0] led
);

    // Elaboration-time parameter sanity checks.
    if (KEY_NUM < 1 || KEY_NUM > 16) begin : g_bad_key_num
        $error("key_led_ctrl_multi: KEY_NUM must be 1..16");
    end
    if (DEBOUNCE_CNT < 2 || LONG_CNT <= DEBOUNCE_CNT) begin : g_bad_cnt
        $error("key_led_ctrl_multi: need DEBOUNCE_CNT >= 2 and LONG_CNT > DEBOUNCE_CNT");
    end
    if (REPEAT_CNT < 2) begin : g_bad_repeat
        $error("key_led_ctrl_multi: REPEAT_CNT must be >= 2");
    end

    // Counters stop at their terminal value, so $clog2 of the count is enough.
    localparam int              DW     = $clog2(DEBOUNCE_CNT);
    localparam int              HW     = $clog2(LONG_CNT);
    localparam logic [DW-1:0]   D_TERM = DW'(DEBOUNCE_CNT - 1);
    localparam logic [HW-1:0]   H_TERM = HW'(LONG_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam int              RW     = $clog2(REPEAT_CNT);
    localparam logic [RW-1:0]   R_TERM = RW'(REPEAT_CNT - 1);
`endif

    typedef enum logic [1:0] {IDLE, FILT_P, PRESSED, FILT_R} state_e;

    logic [KEY_NUM-1:0] sync1_q, sync2_q, ks;
    state_e             state_q [KEY_NUM];
    state_e             state_d [KEY_NUM];
    logic [DW-1:0]      dcnt_q  [KEY_NUM];
    logic [DW-1:0]      dcnt_d  [KEY_NUM];
    logic [HW-1:0]      hcnt_q  [KEY_NUM];
    logic [HW-1:0]      hcnt_d  [KEY_NUM];
`ifdef KEY_REPEAT_EN
    logic [RW-1:0]      rcnt_q  [KEY_NUM];
    logic [RW-1:0]      rcnt_d  [KEY_NUM];
`endif
    logic [KEY_NUM-1:0] long_done_q, long_done_d;
    logic [KEY_NUM-1:0] key_out_q, key_out_d;
    logic [KEY_NUM-1:0] p_flag_q, p_flag_d;
    logic [KEY_NUM-1:0] r_flag_q, r_flag_d;
    logic [KEY_NUM-1:0] long_flag_q, long_flag_d;
    logic [KEY_NUM-1:0] led_q, led_d;
    logic [KEY_NUM-1:0] long_tgl;

    // Two-flop synchroniser; reset loads the released pin level.
    always_ff @(posedge sys_clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (rst) begin
            sync1_q <= {KEY_NUM{~KEY_ACTIVE}};
            sync2_q <= {KEY_NUM{~KEY_ACTIVE}};
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Normalised key state: 1 = pressed regardless of pin polarity.
    assign ks = KEY_ACTIVE ? sync2_q : ~sync2_q;

    // Per-channel debounce FSM, hold/repeat counters and event flags.
    always_comb begin
        for (int i = 0; i < KEY_NUM; i++) begin
            // NOTE: every _d takes its hold value first so no path can infer a latch.
            state_d[i]     = state_q[i];
            dcnt_d[i]      = dcnt_q[i];
            hcnt_d[i]      = hcnt_q[i];
            long_done_d[i] = long_done_q[i];
            key_out_d[i]   = key_out_q[i];
            p_flag_d[i]    = 1'b0;
            r_flag_d[i]    = 1'b0;
            long_flag_d[i] = 1'b0;
`ifdef KEY_REPEAT_EN
            rcnt_d[i]      = rcnt_q[i];
`endif
            case (state_q[i])
                IDLE: begin
                    if (ks[i]) begin
                        state_d[i] = FILT_P;
                        dcnt_d[i]  = '0;
                    end
                end
                FILT_P: begin
                    if (!ks[i]) begin
                        state_d[i] = IDLE;
                    end else if (dcnt_q[i] == D_TERM) begin
                        state_d[i]     = PRESSED;
                        key_out_d[i]   = 1'b1;
                        p_flag_d[i]    = 1'b1;
                        hcnt_d[i]      = '0;
                        long_done_d[i] = 1'b0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!ks[i]) begin
                        state_d[i] = FILT_R;
                        dcnt_d[i]  = '0;
                    end
                end
                FILT_R: begin
                    if (ks[i]) begin
                        state_d[i] = PRESSED;
                    end else if (dcnt_q[i] == D_TERM) begin
                        state_d[i]   = IDLE;
                        key_out_d[i] = 1'b0;
                        r_flag_d[i]  = 1'b1;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DW'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            // Hold time survives release bounces; the release-accept cycle
            // carries only key_r_flag so flags stay mutually exclusive.
            if ((state_q[i] == PRESSED || state_q[i] == FILT_R) && !r_flag_d[i]) begin
                if (hcnt_q[i] != H_TERM) begin
                    hcnt_d[i] = hcnt_q[i] + HW'(1);
                end
                if (hcnt_q[i] == H_TERM - HW'(1) && !long_done_q[i]) begin
                    long_flag_d[i] = 1'b1;
                    long_done_d[i] = 1'b1;
`ifdef KEY_REPEAT_EN
                    rcnt_d[i]      = '0;
`endif
                end
`ifdef KEY_REPEAT_EN
                if (long_done_q[i]) begin
                    if (rcnt_q[i] == R_TERM) begin
                        long_flag_d[i] = 1'b1;
                        rcnt_d[i]      = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RW'(1);
                    end
                end
`endif
            end
        end
    end

    // Long-press pulses toggle the LED in modes 0/1 only when repeats exist.
`ifdef KEY_REPEAT_EN
    assign long_tgl = long_flag_q;
`else
    assign long_tgl = '0;
`endif

    // LED action from registered flags, one cycle after the flag.
    always_comb begin
        for (int i = 0; i < KEY_NUM; i++) begin
            led_d[i] = led_q[i];
            case (mode)
                2'd0: if (r_flag_q[i] || long_tgl[i]) led_d[i] = ~led_q[i];
                2'd1: if (p_flag_q[i] || long_tgl[i]) led_d[i] = ~led_q[i];
                2'd2: led_d[i] = key_out_q[i];
                default: begin
                    if (long_flag_q[i]) begin
                        led_d[i] = 1'b0;
                    end else if (r_flag_q[i] && !long_done_q[i]) begin
                        led_d[i] = ~led_q[i];
                    end
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
`ifdef KEY_REPEAT_EN
                rcnt_q[i]  <= '0;
`endif
            end
            long_done_q <= '0;
            key_out_q   <= '0;
            p_flag_q    <= '0;
            r_flag_q    <= '0;
            long_flag_q <= '0;
            led_q       <= '0;
        end else begin
            for (int i = 0; i < KEY_NUM; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
`ifdef KEY_REPEAT_EN
                rcnt_q[i]  <= rcnt_d[i];
`endif
            end
            long_done_q <= long_done_d;
            key_out_q   <= key_out_d;
            p_flag_q    <= p_flag_d;
            r_flag_q    <= r_flag_d;
            long_flag_q <= long_flag_d;
            led_q       <= led_d;
        end
    end

    assign key_out       = key_out_q;
    assign key_p_flag    = p_flag_q;
    assign key_r_flag    = r_flag_q;
    assign key_long_flag = long_flag_q;
    assign led           = led_q;

endmodule

// File: tb/tb_key_led_ctrl_multi.sv
// tb_key_led_ctrl_multi: directed checks of key_led_ctrl_multi with
// DEBOUNCE_CNT=8, LONG_CNT=40, REPEAT_CNT=16, KEY_NUM=4, active-low keys.
module tb_key_led_ctrl_multi;

    localparam int KN = 4;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [KN-1:0] key;
    logic [1:0]    mode;
    logic [KN-1:0] key_out, key_p_flag, key_r_flag, key_long_flag, led;

    key_led_ctrl_multi #(
        .KEY_NUM      (KN),
        .DEBOUNCE_CNT (8),
        .LONG_CNT     (40),
        .KEY_ACTIVE   (1'b0),
        .REPEAT_CNT   (16)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .key           (key),
        .mode          (mode),
        .key_out       (key_out),
        .key_p_flag    (key_p_flag),
        .key_r_flag    (key_r_flag),
        .key_long_flag (key_long_flag),
        .led           (led)
    );

    always #5 sys_clk = ~sys_clk;

    // Event recorder: cycle count and per-channel pulse counts/last cycles,
    // sampled 1 time unit after each rising edge.
    int            cyc = 0;
    int            p_cnt [KN];
    int            r_cnt [KN];
    int            l_cnt [KN];
    int            p_cyc [KN];
    int            r_cyc [KN];
    int            l_cyc [KN];
    int            rise_cyc [KN];
    logic [KN-1:0] led_prev = '0;

    always @(posedge sys_clk) begin
        #1;
        cyc = cyc + 1;
        for (int i = 0; i < KN; i++) begin
            if (key_p_flag[i] === 1'b1) begin
                p_cnt[i] = p_cnt[i] + 1;
                p_cyc[i] = cyc;
            end
            if (key_r_flag[i] === 1'b1) begin
                r_cnt[i] = r_cnt[i] + 1;
                r_cyc[i] = cyc;
            end
            if (key_long_flag[i] === 1'b1) begin
                l_cnt[i] = l_cnt[i] + 1;
                l_cyc[i] = cyc;
            end
            if (led[i] === 1'b1 && led_prev[i] !== 1'b1) rise_cyc[i] = cyc;
        end
        led_prev = led;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic int total(input int a [KN]);
        int s = 0;
        for (int i = 0; i < KN; i++) s += a[i];
        return s;
    endfunction

    initial begin
        int c0, c1, c2;

        // Reset state, then 100 idle cycles with all keys released.
        rst  = 1'b1;
        key  = 4'hF;
        mode = 2'd0;
        step(3);
        check("rst_key_out", 32'(key_out), 0);
        check("rst_led", 32'(led), 0);
        check("rst_flags", 32'({key_p_flag, key_r_flag, key_long_flag}), 0);
        rst = 1'b0;
        step(100);
        check("idle_key_out", 32'(key_out), 0);
        check("idle_led", 32'(led), 0);
        check("idle_events", total(p_cnt) + total(r_cnt) + total(l_cnt), 0);

        // Bounce on key[0]: 5 low cycles is shorter than the filter.
        key[0] = 1'b0;
        step(5);
        key[0] = 1'b1;
        step(30);
        check("bounce_p", p_cnt[0], 0);
        check("bounce_r", r_cnt[0], 0);
        check("bounce_key_out", 32'(key_out[0]), 0);
        check("bounce_led", 32'(led[0]), 0);

        // Mode 0: 20-cycle press on key[1], toggle on release.
        c0 = cyc;
        key[1] = 1'b0;
        step(11);
        check("m0_p_cnt", p_cnt[1], 1);
        check("m0_p_cyc", p_cyc[1], c0 + 11);
        step(4);
        check("m0_key_out_held", 32'(key_out[1]), 1);
        check("m0_led_held", 32'(led[1]), 0);
        step(5);
        c1 = cyc;
        key[1] = 1'b1;
        step(11);
        check("m0_r_cyc", r_cyc[1], c1 + 11);
        check("m0_led_before", 32'(led[1]), 0);
        step(1);
        check("m0_led_after", 32'(led[1]), 1);
        check("m0_led_rise_cyc", rise_cyc[1], c1 + 12);
        step(20);
        check("m0_no_long", l_cnt[1], 0);
        check("m0_key_out_rel", 32'(key_out[1]), 0);

        // Mode 3: long press on key[2] forces LED off, release does not toggle.
        mode = 2'd3;
        c0 = cyc;
        key[2] = 1'b0;
        step(60);
        check("m3_long_cnt", l_cnt[2], 1);
        check("m3_long_cyc", l_cyc[2], c0 + 50);
        check("m3_led_long", 32'(led[2]), 0);
        check("m3_key_out_held", 32'(key_out[2]), 1);
        c1 = cyc;
        key[2] = 1'b1;
        step(15);
        check("m3_r_cnt", r_cnt[2], 1);
        check("m3_r_cyc", r_cyc[2], c1 + 11);
        check("m3_led_rel_long", 32'(led[2]), 0);
        // Short press in mode 3 toggles on release.
        c2 = cyc;
        key[2] = 1'b0;
        step(20);
        key[2] = 1'b1;
        step(15);
        check("m3_r_cnt2", r_cnt[2], 2);
        check("m3_long_cnt2", l_cnt[2], 1);
        check("m3_led_short", 32'(led[2]), 1);
        check("m3_led_rise_cyc", rise_cyc[2], c2 + 32);

        // Mode 2: LEDs follow key_out from the next cycle.
        mode = 2'd2;
        step(1);
        check("m2_switch_led", 32'(led), 0);
        c0 = cyc;
        key[0] = 1'b0;
        key[3] = 1'b0;
        step(11);
        check("m2_p_cyc0", p_cyc[0], c0 + 11);
        check("m2_p_cyc3", p_cyc[3], c0 + 11);
        check("m2_key_out", 32'(key_out), 32'h9);
        check("m2_led_lag", 32'(led), 0);
        step(1);
        check("m2_led_follow", 32'(led), 32'h9);
        // Reset while both keys are held.
        step(13);
        rst = 1'b1;
        step(2);
        check("m2_rst_led", 32'(led), 0);
        check("m2_rst_key_out", 32'(key_out), 0);
        key = 4'hF;
        rst = 1'b0;
        step(30);
        check("m2_rst_no_r0", r_cnt[0], 0);
        check("m2_rst_no_r3", r_cnt[3], 0);
        check("m2_rst_p3", p_cnt[3], 1);
        check("m2_rst_led_after", 32'(led), 0);

        // Mode 1: 100-cycle hold on key[0].
        mode = 2'd1;
        c0 = cyc;
        key[0] = 1'b0;
        step(12);
        check("m1_p_cnt", p_cnt[0], 2);
        check("m1_led_press", 32'(led[0]), 1);
        step(38);
        check("m1_first_long_cnt", l_cnt[0], 1);
        check("m1_first_long_cyc", l_cyc[0], c0 + 50);
        step(2);
`ifdef KEY_REPEAT_EN
        check("m1_led_after_long", 32'(led[0]), 0);
`else
        check("m1_led_after_long", 32'(led[0]), 1);
`endif
        step(48);
        key[0] = 1'b1;
        step(15);
        check("m1_r_cnt", r_cnt[0], 1);
        check("m1_key_out_rel", 32'(key_out[0]), 0);
        check("m1_led_final", 32'(led[0]), 1);
`ifdef KEY_REPEAT_EN
        check("m1_long_total", l_cnt[0], 4);
        check("m1_last_long_cyc", l_cyc[0], c0 + 98);
`else
        check("m1_long_total", l_cnt[0], 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_led_ctrl_multi.md
Name: key_led_ctrl_multi

Overview:
- N-channel push-button front end with integrated debounce, press/release/long-press event detection and a per-channel LED state register with a runtime-selectable action mode.
- Successor to the single-key debounce + toggle-LED test block.
- Sits between board key pins and board LEDs; event flags are also exported for other logic.

Parameters:
- KEY_NUM, 4: number of independent key/LED channels (1..16).
- DEBOUNCE_CNT, 1000000: cycles a level must be stable to be accepted (20 ms at 50 MHz); minimum 2.
- LONG_CNT, 50000000: debounced-held cycles before a long-press event (1 s at 50 MHz); must be greater than DEBOUNCE_CNT.
- KEY_ACTIVE, 0: pin level meaning "pressed" (0 = active-low keys).
- REPEAT_CNT, 10000000: auto-repeat period; used only with KEY_REPEAT_EN.

Ports:
- sys_clk, input, 1: single system clock; all logic on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- key, input, KEY_NUM: raw asynchronous key pins.
- mode, input, 2: LED action mode, common to all channels, sampled every cycle.
- key_out, output, KEY_NUM: debounced level; 1 = pressed.
- key_p_flag, output, KEY_NUM: 1-cycle pulse on accepted press.
- key_r_flag, output, KEY_NUM: 1-cycle pulse on accepted release.
- key_long_flag, output, KEY_NUM: 1-cycle pulse on long-press threshold (and on repeats, if enabled).
- led, output, KEY_NUM: LED drive; 1 = on.

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchronisers loaded with the inactive level, every FSM in IDLE, all counters 0.
- Per channel: 2-flop synchroniser, then normalise: ks = (sync == KEY_ACTIVE).
- Per-channel FSM states and transitions:
  - IDLE: if ks=1, go to FILT_P with dcnt=0.
  - FILT_P: if ks=0, return to IDLE (bounce, no event). Otherwise increment dcnt. At dcnt == DEBOUNCE_CNT-1: go to PRESSED, key_out<=1, key_p_flag pulses, hcnt<=0, long_done<=0.
  - PRESSED: hcnt increments, saturating at LONG_CNT-1. On reaching LONG_CNT-1 with long_done=0: key_long_flag pulses, long_done<=1. If ks=0: go to FILT_R with dcnt=0; hcnt keeps counting.
  - FILT_R: if ks=1, return to PRESSED (no event; hcnt not reset). At dcnt == DEBOUNCE_CNT-1: go to IDLE, key_out<=0, key_r_flag pulses.
- Counter widths are $clog2 of the largest terminal value; no wrap, since counters stop at their terminal value.
- Latency: clean pin edge to flag or key_out change = DEBOUNCE_CNT+3 rising edges (2 sync, 1 FSM entry, DEBOUNCE_CNT-1 count, 1 register).
- Flags are registered, exactly one cycle wide, and mutually exclusive per channel except:
  - with KEY_REPEAT_EN, key_long_flag may pulse while key_out=1;
  - if the long threshold and FILT_R entry fall on the same cycle, key_long_flag still fires.
- LED modes, applied per channel from registered flags, one cycle after the flag:
  - mode 0: toggle on key_r_flag.
  - mode 1: toggle on key_p_flag.
  - mode 2: led follows key_out, one cycle later.
  - mode 3: key_r_flag toggles only if long_done=0 (short press); key_long_flag forces led<=0.
- Mode change: led holds its current value; mode 2 takes effect the next cycle. No flag is lost or replayed.
- Channels are fully independent; simultaneous events on several channels are all honoured in the same cycle.
- Reset mid-debounce or mid-hold: no flag emitted, led<=0.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: after the first long pulse, while in PRESSED (or FILT_R), key_long_flag re-pulses every REPEAT_CNT cycles until release is accepted. In modes 0/1 each repeat pulse also toggles led.
- Undefined: at most one key_long_flag per press; repeat counter logic absent.

Test Plan (DEBOUNCE_CNT=8, LONG_CNT=40, REPEAT_CNT=16, KEY_NUM=4, KEY_ACTIVE=0):
- Reset released, keys held 1 for 100 cycles -> all outputs 0, no flags.
- key[0] low for 5 cycles then high (bounce) -> no flags, key_out=0, led=0.
- mode 0, key[1] low 20 cycles then high 20 cycles -> key_p_flag[1] at 11 cycles after the falling edge, key_r_flag[1] 11 cycles after the rising edge, led[1] 0 to 1 one cycle after key_r_flag.
- mode 3, key[2] held low 60 cycles -> one key_long_flag[2], led[2]=0; release -> key_r_flag[2], led stays 0. A 20-cycle press -> led[2] toggles to 1.
- mode 2, keys 0 and 3 pressed on the same cycle -> key_p_flag[0] and key_p_flag[3] pulse in the same cycle, led[0], led[3] rise together. rst pulsed mid-hold -> led=0, no key_r_flag.
- KEY_REPEAT_EN, mode 1, key[0] held 100 cycles -> key_long_flag[0] at hold cycle 40, then every 16 cycles (4 pulses in total); led[0] toggles on each.
